alu_pipe: RTL and testbench

//  Parametrised, pipelined successor to the team's 4-bit combinational ALU. WIDTH-bit

---
 rtl/alu_pipe_if.sv | 33 +++
 rtl/alu_pipe.sv | 133 +++++++++++++
 tb/tb_alu_pipe.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
// ============================================================================
// Module      : alu_pipe_if
// Description : Operand/result handshake bundle for alu_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_pipe_if #(
   parameter int WIDTH = 4
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [2:0]       sel;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Y;
   logic [3:0]       flags;

   // master is the producer/consumer side, slave is the ALU
   modport master (
      output in_valid, A, B, sel, out_ready,
      input  in_ready, out_valid, Y, flags
   );

   modport slave (
      input  in_valid, A, B, sel, out_ready,
      output in_ready, out_valid, Y, flags
   );
endinterface

`default_nettype wire

// File: rtl/alu_pipe.sv
// ============================================================================
// Module      : alu_pipe
// Description : Two-stage pipelined WIDTH-bit ALU with valid/ready on both
//               sides. Define ALU_PIPE_SAT_EN for unsigned-saturating ADD/SUB.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_pipe #(
   parameter int WIDTH = 4
) (
   input  wire logic   clk,
   input  wire logic   rst,
   alu_pipe_if.slave   alu
);

   localparam int       SHW        = $clog2(WIDTH);
   localparam bit [2:0] c_OP_ADD   = 3'b000;
   localparam bit [2:0] c_OP_SUB   = 3'b001;
   localparam bit [2:0] c_OP_AND   = 3'b010;
   localparam bit [2:0] c_OP_OR    = 3'b011;
   localparam bit [2:0] c_OP_NOT   = 3'b100;
   localparam bit [2:0] c_OP_XOR   = 3'b101;
   localparam bit [2:0] c_OP_SHL   = 3'b110;
   localparam bit [2:0] c_OP_SHR   = 3'b111;

   logic             r_s1_valid;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [2:0]       r_sel;
   logic             r_s2_valid;
   logic [WIDTH-1:0] r_y;
   logic [3:0]       r_flags;

   logic             w_adv1;
   logic             w_adv2;
   logic [SHW-1:0]   w_amt;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_diff;
   logic [WIDTH:0]   w_shl;
   logic [WIDTH:0]   w_shr;
   logic [WIDTH-1:0] w_y;
   logic             w_c;
   logic             w_v;

   assign w_adv2 = !r_s2_valid || alu.out_ready;
   assign w_adv1 = !r_s1_valid || w_adv2;

   assign alu.in_ready  = w_adv1;
   assign alu.out_valid = r_s2_valid;
   assign alu.Y         = r_y;
   assign alu.flags     = r_flags;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_a        <= '0;
         r_b        <= '0;
         r_sel      <= '0;
      end else if (w_adv1) begin
         r_s1_valid <= alu.in_valid;
         if (alu.in_valid) begin
            r_a   <= alu.A;
            r_b   <= alu.B;
            r_sel <= alu.sel;
         end
      end
   end

   // Extra bit catches carry-out (SHL) or the last bit dropped off the LSB (SHR)
   assign w_amt  = r_b[SHW-1:0];
   assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
   assign w_diff = {1'b0, r_a} - {1'b0, r_b};
   assign w_shl  = {1'b0, r_a} << w_amt;
   assign w_shr  = {r_a, 1'b0} >> w_amt;

   always_comb begin
      w_y = '0;
      w_c = 1'b0;
      w_v = 1'b0;
      case (r_sel)
         c_OP_ADD: begin
            w_y = w_sum[WIDTH-1:0];
            w_c = w_sum[WIDTH];
            w_v = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
`ifdef ALU_PIPE_SAT_EN
            if (w_sum[WIDTH]) w_y = '1;
`endif
         end
         c_OP_SUB: begin
            w_y = w_diff[WIDTH-1:0];
            w_c = w_diff[WIDTH];
            w_v = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
`ifdef ALU_PIPE_SAT_EN
            if (w_diff[WIDTH]) w_y = '0;
`endif
         end
         c_OP_AND: w_y = r_a & r_b;
         c_OP_OR:  w_y = r_a | r_b;
         c_OP_NOT: w_y = ~r_a;
         c_OP_XOR: w_y = r_a ^ r_b;
         c_OP_SHL: begin
            w_y = w_shl[WIDTH-1:0];
            w_c = w_shl[WIDTH];
         end
         c_OP_SHR: begin
            w_y = w_shr[WIDTH:1];
            w_c = w_shr[0];
         end
         default: begin
            w_y = '0;
            w_c = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_y        <= '0;
         r_flags    <= '0;
      end else if (w_adv2) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_y     <= w_y;
            r_flags <= {w_c, w_v, w_y[WIDTH-1], (w_y == '0)};
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe.sv
// ============================================================================
// Module      : tb_alu_pipe
// Description : Scoreboard bench for alu_pipe (WIDTH=4 and WIDTH=8 instances).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_pipe;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic [7:0]  exp4_q[$];
   logic [11:0] exp8_q[$];
   logic        low_seen;

   alu_pipe_if #(.WIDTH(4)) bus4 ();
   alu_pipe_if #(.WIDTH(8)) bus8 ();

   alu_pipe #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .alu(bus4.slave));
   alu_pipe #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .alu(bus8.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s,
                        input logic [3:0] ey, input logic [3:0] ef);
      int n = 0;
      @(negedge clk);
      bus4.in_valid = 1'b1;
      bus4.A        = a;
      bus4.B        = b;
      bus4.sel      = s;
      exp4_q.push_back({ey, ef});
      #2;
      while (!bus4.in_ready && n < 50) begin
         @(negedge clk);
         #2;
         n++;
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: in_ready stuck at 0, required 1");
      end
      @(posedge clk);
   endtask

   task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s,
                        input logic [7:0] ey, input logic [3:0] ef);
      @(negedge clk);
      bus8.in_valid = 1'b1;
      bus8.A        = a;
      bus8.B        = b;
      bus8.sel      = s;
      exp8_q.push_back({ey, ef});
      @(posedge clk);
      #1 bus8.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp4_q.size() != 0 || exp8_q.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain4_left", 12'(exp4_q.size()), 12'd0);
      check("drain8_left", 12'(exp8_q.size()), 12'd0);
   endtask

   // Monitors: compare head of queue while out_valid; pop only on handshake
   initial forever begin
      @(negedge clk);
      #3;
      if (!rst && bus4.out_valid) begin
         if (exp4_q.size() == 0) begin
            check("unexpected4", {4'd0, bus4.Y, bus4.flags}, 12'hFFF);
         end else begin
            check("result4", {4'd0, bus4.Y, bus4.flags}, {4'd0, exp4_q[0]});
            if (bus4.out_ready) void'(exp4_q.pop_front());
         end
      end
   end

   initial forever begin
      @(negedge clk);
      #3;
      if (!rst && bus8.out_valid) begin
         if (exp8_q.size() == 0) begin
            check("unexpected8", {bus8.Y, bus8.flags}, 12'hFFF);
         end else begin
            check("result8", {bus8.Y, bus8.flags}, exp8_q[0]);
            if (bus8.out_ready) void'(exp8_q.pop_front());
         end
      end
   end

   initial begin
      checks = 0;
      errors = 0;
      low_seen = 1'b0;
      rst = 1'b1;
      bus4.in_valid = 1'b0; bus4.A = '0; bus4.B = '0; bus4.sel = '0; bus4.out_ready = 1'b1;
      bus8.in_valid = 1'b0; bus8.A = '0; bus8.B = '0; bus8.sel = '0; bus8.out_ready = 1'b1;
      #3;
      check("rst_out_valid", {11'd0, bus4.out_valid}, 12'd0);
      check("rst_y",         {8'd0, bus4.Y},          12'd0);
      check("rst_flags",     {8'd0, bus4.flags},      12'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1 check("idle_in_ready", {11'd0, bus4.in_ready}, 12'd1);

      // Single beat on idle pipe: latency
      send4(4'b1100, 4'b0111, 3'b000,
`ifdef ALU_PIPE_SAT_EN
            4'b1111, 4'b1010);
`else
            4'b0011, 4'b1000);
`endif
      #1 bus4.in_valid = 1'b0;
      check("lat_stage1", {11'd0, bus4.out_valid}, 12'd0);
      @(posedge clk);
      #1 check("lat_stage2", {11'd0, bus4.out_valid}, 12'd1);

      send4(4'b0011, 4'b0101, 3'b001,
`ifdef ALU_PIPE_SAT_EN
            4'b0000, 4'b1001);
`else
            4'b1110, 4'b1010);
`endif

      // Back-to-back ops on A=0101, B=0011
      send4(4'b0101, 4'b0011, 3'b000, 4'b1000, 4'b0110);
      send4(4'b0101, 4'b0011, 3'b001, 4'b0010, 4'b0000);
      send4(4'b0101, 4'b0011, 3'b010, 4'b0001, 4'b0000);
      send4(4'b0101, 4'b0011, 3'b011, 4'b0111, 4'b0000);
      send4(4'b0101, 4'b0011, 3'b100, 4'b1010, 4'b0010);
      send4(4'b0101, 4'b0011, 3'b101, 4'b0110, 4'b0000);

      // Shifts
      send4(4'b1001, 4'b0001, 3'b110, 4'b0010, 4'b1000);
      send4(4'b1001, 4'b0001, 3'b111, 4'b0100, 4'b1000);
      send4(4'b1001, 4'b0000, 3'b110, 4'b1001, 4'b0010);
      send4(4'b1001, 4'b0000, 3'b111, 4'b1001, 4'b0010);
      #1 bus4.in_valid = 1'b0;
      drain();

      // Backpressure: 6 beats of i+1 with consumer stalled
      fork
         begin
            for (int i = 0; i < 6; i++)
               send4(4'(i), 4'b0001, 3'b000, 4'(i + 1), 4'b0000);
            #1 bus4.in_valid = 1'b0;
         end
         begin
            @(negedge clk);
            bus4.out_ready = 1'b0;
            repeat (4) begin
               @(negedge clk);
               #2 if (!bus4.in_ready) low_seen = 1'b1;
            end
            @(negedge clk);
            bus4.out_ready = 1'b1;
         end
      join
      check("bp_in_ready_low", {11'd0, low_seen}, 12'd1);
      drain();

      // Reset with two beats in flight
      @(negedge clk);
      bus4.out_ready = 1'b0;
      send4(4'b0001, 4'b0001, 3'b000, 4'b0010, 4'b0000);
      send4(4'b0010, 4'b0001, 3'b000, 4'b0011, 4'b0000);
      #1 bus4.in_valid = 1'b0;
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check("midrst_out_valid", {11'd0, bus4.out_valid}, 12'd0);
      check("midrst_y",         {8'd0, bus4.Y},          12'd0);
      check("midrst_flags",     {8'd0, bus4.flags},      12'd0);
      exp4_q.delete();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      bus4.out_ready = 1'b1;
      repeat (4) @(negedge clk);
      #3 check("post_rst_quiet", {11'd0, bus4.out_valid}, 12'd0);

      // WIDTH=8 overflow and zero
      send8(8'h7F, 8'h01, 3'b000, 8'h80, 4'b0110);
      send8(8'h80, 8'h80, 3'b001, 8'h00, 4'b0001);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1);
   end

endmodule

`default_nettype wire
